// File: rtl/mem_ctrl2_if.sv
// mem_ctrl2_if: bus 2 (cache <-> memory line transfer) with shared C2/D2 wires.
// Both sides present a value plus an enable; the shared wires are resolved here.
// Ports: A2_WIRE, D2_WIRE, C2_WIRE, M_DUMP, per-side drive controls, dump scan outputs.
interface mem_ctrl2_if #(
  parameter int ADDR2_BUS_SIZE = 15,
  parameter int DATA_BUS_SIZE  = 16,
  parameter int CTR2_BUS_SIZE  = 2,
  parameter int LINE_BITS      = 128
);
  logic [ADDR2_BUS_SIZE-1:0] A2_WIRE;
  wire  [DATA_BUS_SIZE-1:0]  D2_WIRE;
  wire  [CTR2_BUS_SIZE-1:0]  C2_WIRE;
  logic                      M_DUMP;

  // cache-side drivers
  logic [DATA_BUS_SIZE-1:0]  cache_d2;
  logic                      cache_d2_en;
  logic [CTR2_BUS_SIZE-1:0]  cache_c2;
  logic                      cache_c2_en;

  // memory-side drivers
  logic [DATA_BUS_SIZE-1:0]  mem_d2;
  logic                      mem_d2_en;
  logic [CTR2_BUS_SIZE-1:0]  mem_c2;
  logic                      mem_c2_en;

  // dump scan: one written (non-initial) line per dump_vld pulse
  logic                      dump_vld;
  logic [ADDR2_BUS_SIZE-1:0] dump_addr;
  logic [LINE_BITS-1:0]      dump_line;

  assign D2_WIRE = mem_d2_en   ? mem_d2   : 'z;
  assign D2_WIRE = cache_d2_en ? cache_d2 : 'z;
  assign C2_WIRE = mem_c2_en   ? mem_c2   : 'z;
  assign C2_WIRE = cache_c2_en ? cache_c2 : 'z;

  modport slave (
    input  A2_WIRE, D2_WIRE, C2_WIRE, M_DUMP,
    output mem_d2, mem_d2_en, mem_c2, mem_c2_en,
    output dump_vld, dump_addr, dump_line
  );

  modport master (
    output A2_WIRE, M_DUMP, cache_d2, cache_d2_en, cache_c2, cache_c2_en,
    input  D2_WIRE, C2_WIRE, mem_d2_en, mem_c2_en,
    input  dump_vld, dump_addr, dump_line
  );
endinterface

// File: rtl/mem_ctrl2.sv
// mem_ctrl2: main-memory responder on bus 2; serves whole-line reads and write-backs
// from the cache, answering each command with RESPONSE a fixed MEM_DELAY after it.
// Ports: CLK, RESET (async, active-high), bus (mem_ctrl2_if.slave).
module mem_ctrl2 #(
  parameter int ADDR2_BUS_SIZE    = 15,
  parameter int CACHE_OFFSET_SIZE = 4,
  parameter int CACHE_LINE_SIZE   = 16,
  parameter int DATA_BUS_SIZE     = 16,
  parameter int CTR2_BUS_SIZE     = 2,
  parameter int MEM_DELAY         = 100,
  parameter int INIT_MODE         = 0,
  parameter int SEED              = 225526
) (
  input  logic       CLK,
  input  logic       RESET,
  mem_ctrl2_if.slave bus
);

  localparam int BEATS     = CACHE_LINE_SIZE / 2;
  localparam int LINE_BITS = CACHE_LINE_SIZE * 8;
  localparam int LINES     = 1 << ADDR2_BUS_SIZE;
  localparam int BA_W      = ADDR2_BUS_SIZE + CACHE_OFFSET_SIZE;
  localparam int CNT_W     = $clog2(MEM_DELAY + BEATS + 1);
  localparam int BI_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CTR2_BUS_SIZE-1:0] C2_NOP   = CTR2_BUS_SIZE'(0);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_RESP  = CTR2_BUS_SIZE'(1);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_READ  = CTR2_BUS_SIZE'(2);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE = CTR2_BUS_SIZE'(3);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    TURN,
    BUSY,
    SEND,
    RESP,
    RELEASE
  } state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;   // cycle number of the current transaction
  logic                      is_wr;
  logic [ADDR2_BUS_SIZE-1:0] line_addr;
  logic [LINE_BITS-1:0]      wbuf;

  logic                      accept_rd, accept_wr, accept;
  logic                      cap, commit;
  logic [BI_W-1:0]           cap_idx, beat_idx;
  logic [CNT_W-1:0]          turn_last;

  logic                      c2_en, d2_en;
  logic [CTR2_BUS_SIZE-1:0]  c2_val;
  logic [DATA_BUS_SIZE-1:0]  d2_val;

  // Backing store: only written lines live in line_mem; everything else reads the
  // power-on pattern, so contents survive RESET and need no load sequence.
  logic [LINE_BITS-1:0]      line_mem [LINES];
  logic                      dirty    [LINES];
  logic [LINE_BITS-1:0]      rd_line;

  logic                      m_dump_q, dump_act, dump_vld_q;
  logic [ADDR2_BUS_SIZE-1:0] dump_idx, dump_addr_q;
  logic [LINE_BITS-1:0]      dump_line_q;

  function automatic logic [LINE_BITS-1:0] init_line(input logic [ADDR2_BUS_SIZE-1:0] la);
    logic [LINE_BITS-1:0] l;
    logic [BA_W-1:0]      ba;
    logic [31:0]          h;
    l = '0;
    for (int k = 0; k < CACHE_LINE_SIZE; k++) begin
      ba = {la, CACHE_OFFSET_SIZE'(k)};
      // integer hash of (byte address, SEED) gives a repeatable pseudo-random byte
      h = (32'(ba) * 32'h9E37_79B1) ^ 32'(SEED);
      h = h ^ (h >> 15);
      h = h * 32'h85EB_CA6B;
      h = h ^ (h >> 13);
      l[8*k +: 8] = (INIT_MODE == 0) ? ba[7:0] : h[7:0];
    end
    return l;
  endfunction

  assign rd_line   = dirty[line_addr] ? line_mem[line_addr] : init_line(line_addr);
  assign turn_last = is_wr ? CNT_W'(BEATS) : CNT_W'(1);
  assign beat_idx  = BI_W'(cnt - CNT_W'(MEM_DELAY));
  assign accept    = accept_rd | accept_wr;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      is_wr     <= 1'b0;
      line_addr <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        line_addr <= bus.A2_WIRE;
        is_wr     <= accept_wr;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    accept_rd = 1'b0;
    accept_wr = 1'b0;
    cap       = 1'b0;
    cap_idx   = '0;
    commit    = 1'b0;
    c2_en     = 1'b0;
    c2_val    = C2_NOP;
    d2_en     = 1'b0;
    d2_val    = '0;
    case (state)
      // RELEASE already has the wires let go, so it samples commands like IDLE
      IDLE, RELEASE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        if (bus.C2_WIRE == C2_READ) begin
          state_nxt = TURN;
          accept_rd = 1'b1;
        end else if (bus.C2_WIRE == C2_WRITE) begin
          state_nxt = RECV;
          accept_wr = 1'b1;
          cap       = 1'b1;   // beat 0 rides with the command
        end
      end
      RECV: begin
        if (cnt == CNT_W'(BEATS - 1)) begin
          state_nxt = TURN;
        end else begin
          cap     = 1'b1;
          cap_idx = BI_W'(cnt + 1'b1);
        end
      end
      TURN: begin
        if (cnt == turn_last) state_nxt = BUSY;
      end
      BUSY: begin
        c2_en = 1'b1;
        if (cnt == CNT_W'(MEM_DELAY - 1)) begin
          state_nxt = is_wr ? RESP : SEND;
          commit    = is_wr;
        end
      end
      SEND: begin
        c2_en  = 1'b1;
        c2_val = C2_RESP;
        d2_en  = 1'b1;
        d2_val = rd_line[beat_idx*DATA_BUS_SIZE +: DATA_BUS_SIZE];
        if (cnt == CNT_W'(MEM_DELAY + BEATS - 1)) state_nxt = RELEASE;
      end
      RESP: begin
        c2_en     = 1'b1;
        c2_val    = C2_RESP;
        state_nxt = RELEASE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Store and line buffer: not reset, so an abandoned write never reaches line_mem
  // (commit only fires on the BUSY->RESP edge) and stored data survives RESET.
  always_ff @(posedge CLK) begin
    if (commit) begin
      line_mem[line_addr] <= wbuf;
      dirty[line_addr]    <= 1'b1;
    end
    if (cap) wbuf[cap_idx*DATA_BUS_SIZE +: DATA_BUS_SIZE] <= bus.D2_WIRE;
  end

  // Dump scan: a rising M_DUMP walks every line once and pulses dump_vld for
  // each written line; it only reads the store.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_dump_q    <= 1'b0;
      dump_act    <= 1'b0;
      dump_idx    <= '0;
      dump_vld_q  <= 1'b0;
      dump_addr_q <= '0;
    end else begin
      m_dump_q    <= bus.M_DUMP;
      dump_vld_q  <= dump_act && dirty[dump_idx];
      dump_addr_q <= dump_idx;
      if (dump_act) begin
        dump_idx <= dump_idx + 1'b1;
        if (dump_idx == '1) dump_act <= 1'b0;
      end else if (bus.M_DUMP && !m_dump_q) begin
        dump_act <= 1'b1;
        dump_idx <= '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    dump_line_q <= line_mem[dump_idx];
  end

  assign bus.mem_c2_en = c2_en;
  assign bus.mem_c2    = c2_val;
  assign bus.mem_d2_en = d2_en;
  assign bus.mem_d2    = d2_val;
  assign bus.dump_vld  = dump_vld_q;
  assign bus.dump_addr = dump_addr_q;
  assign bus.dump_line = dump_line_q;

endmodule

// File: doc/mem_ctrl2.md
Name: mem_ctrl2

Overview:
- Memory-side responder for bus 2, the cache↔memory line-transfer bus; the cache is the only initiator on this bus.
- Holds a byte-addressable backing store and serves whole-line reads (C2_READ_LINE) and line write-backs (C2_WRITE_LINE) from the cache.
- Answers every command with C2_RESPONSE after a fixed latency and shares the bidirectional C2/D2 wires via explicit drive/release.
- Simulation model of main memory, written as clocked RTL.

Parameters:
ADDR2_BUS_SIZE, 15, line address width (tag+set bits)
CACHE_OFFSET_SIZE, 4, byte-offset bits within a line
CACHE_LINE_SIZE, 16, bytes per line (= 2**CACHE_OFFSET_SIZE, must be even)
DATA_BUS_SIZE, 16, D2 width; 2 bytes per beat
CTR2_BUS_SIZE, 2, C2 width
MEM_DELAY, 100, cycles from command sample to first C2_RESPONSE cycle; must be ≥ CACHE_LINE_SIZE/2 + 2
INIT_MODE, 0, 0 = byte[i] = i[7:0]; 1 = pseudo-random from SEED
SEED, 225526, random seed for INIT_MODE 1

Ports:
CLK  input  1  clock; all sampling on posedge
RESET  input  1  asynchronous, active-high reset
A2_WIRE  input  ADDR2_BUS_SIZE  line address; sampled only in command cycle
D2_WIRE  inout  DATA_BUS_SIZE  data; [7:0] = lower-address byte, [15:8] = next byte
C2_WIRE  inout  CTR2_BUS_SIZE  command/response: NOP=0, RESPONSE=1, READ_LINE=2, WRITE_LINE=3
M_DUMP  input  1  posedge prints every non-initial line as hex, one line per row

Behaviour:
- Reset (async, any state): state→IDLE, counters cleared, C2_WIRE/D2_WIRE driven Z within the same timestep. Any in-flight transaction is abandoned: no response is issued and no partial write is committed. Store contents are preserved; they are initialised only at time 0 per INIT_MODE.
- Byte address = {line_addr, k}, k in 0..CACHE_LINE_SIZE-1. N = CACHE_LINE_SIZE/2 beats. Beat j carries bytes 2j (D2[7:0]) and 2j+1 (D2[15:8]).
- Cycle numbering: cycle 0 = posedge where IDLE samples C2_WIRE ∈ {READ_LINE, WRITE_LINE}.
- IDLE: samples C2 each posedge. NOP, RESPONSE, X or Z → no action. In the command cycle, latch A2_WIRE into line_addr.
- READ_LINE path: IDLE → TURN (cycle 1, all buses Z) → BUSY (cycles 2..MEM_DELAY-1, drive C2=NOP, D2 Z) → SEND (cycles MEM_DELAY..MEM_DELAY+N-1, drive C2=RESPONSE and D2=beat j=cycle-MEM_DELAY) → RELEASE (cycle MEM_DELAY+N, C2/D2 Z) → IDLE.
- Drive changes happen after the posedge, so the cache sees RESPONSE and beat 0 at posedge MEM_DELAY+1.
- WRITE_LINE path: the cache presents beat 0 in cycle 0. RECV captures beat j at posedge j for j = 0..N-1 into a line buffer; C2/D2 are not driven during RECV.
- WRITE_LINE continued: TURN (cycle N) → BUSY (drive C2=NOP until MEM_DELAY-1) → RESP (cycle MEM_DELAY: C2=RESPONSE, D2 Z; buffer committed to the store in this cycle) → RELEASE → IDLE.
- D2 bits X/Z during RECV are stored as-is; no error is flagged.
- Commands are ignored while not in IDLE. The first command is accepted at the posedge after RELEASE.
- Memory never drives A2. D2 is driven only during SEND.
- M_DUMP is non-destructive and may occur in any state.

Test Plan:
- INIT_MODE 0, READ_LINE A2=0x0003, MEM_DELAY=10 → C2 NOP cycles 2..9; RESPONSE cycles 10..17; beats 0x3130, 0x3332, …, 0x3F3E; C2/D2 Z at cycle 18.
- WRITE_LINE A2=0x0005, beats 0xBBAA, 0xDDCC, then 0x0000 for the remainder → RESPONSE exactly in cycle MEM_DELAY; a subsequent READ_LINE 0x0005 returns 0xBBAA, 0xDDCC, 0x0000….
- READ_LINE issued again during BUSY of a prior read → ignored; only one RESPONSE burst is produced, for the first address.
- RESET asserted at cycle 5 of a WRITE_LINE to 0x0007 → buses Z immediately; no RESPONSE; READ_LINE 0x0007 afterwards returns the original pattern 0x7170….
- Back-to-back: READ_LINE issued in the cycle after RELEASE → accepted, with correct latency.
- C2=RESPONSE or NOP presented by the cache in IDLE → no state change, no drive.
